// File: rtl/esc_mode_sequencer.sv
// esc_mode_sequencer
//   Byte-stream controller. Decodes in-band escape commands (ESC followed by
//   'O', 'P', 'U' or 'L') to select the case-conversion mode. Data bytes are
//   then dropped (OFF), forwarded unchanged (PASS), or forwarded with case
//   conversion (UPPER / LOWER). ESC ESC forwards a literal ESC byte.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   in_data      incoming byte
//   in_valid     in_data valid
//   in_ready     byte accepted when in_valid && in_ready
//   out_data     registered output byte
//   out_valid    out_data valid
//   out_ready    sink accepts when out_valid && out_ready
//   off/pass/upper/lower  one-hot current mode
//   mode_changed one-cycle pulse when the mode register changes value
//   esc_error    one-cycle pulse on an unknown command or escape timeout
module esc_mode_sequencer #(
  parameter int unsigned       DATA_W      = 8,
  parameter logic [DATA_W-1:0] ESC_CODE    = 8'h1B,
  parameter int unsigned       TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              off,
  output logic              pass,
  output logic              upper,
  output logic              lower,
  output logic              mode_changed,
  output logic              esc_error
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b01,
    ST_GOT_ESC = 2'b10
  } state_t;

  typedef enum logic [3:0] {
    MODE_OFF   = 4'b0001,
    MODE_PASS  = 4'b0010,
    MODE_UPPER = 4'b0100,
    MODE_LOWER = 4'b1000
  } mode_t;

  localparam logic [DATA_W-1:0] CMD_OFF   = 8'h4F;
  localparam logic [DATA_W-1:0] CMD_PASS  = 8'h50;
  localparam logic [DATA_W-1:0] CMD_UPPER = 8'h55;
  localparam logic [DATA_W-1:0] CMD_LOWER = 8'h4C;

  // Counter only needs to reach TIMEOUT_CYC-1; the expiry edge is the
  // following idle cycle.
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_t             state;
  mode_t              mode;
  logic [CNT_W-1:0]   count;
  logic               accept;
  logic               legal;
  logic [DATA_W-1:0]  xformed;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  assign off   = mode[0];
  assign pass  = mode[1];
  assign upper = mode[2];
  assign lower = mode[3];

  always_comb begin
    legal = 1'b1;
    if (state != ST_IDLE && state != ST_GOT_ESC) legal = 1'b0;
    case (mode)
      MODE_OFF, MODE_PASS, MODE_UPPER, MODE_LOWER: ;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    xformed = in_data;
    case (mode)
      MODE_UPPER: if (in_data >= 8'h61 && in_data <= 8'h7A) xformed = in_data - 8'h20;
      MODE_LOWER: if (in_data >= 8'h41 && in_data <= 8'h5A) xformed = in_data + 8'h20;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      mode         <= MODE_OFF;
      count        <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      mode_changed <= 1'b0;
      esc_error    <= 1'b0;
    end else begin
      mode_changed <= 1'b0;
      esc_error    <= 1'b0;
      // Drain first; a forward later in this block overrides it, so a
      // simultaneous drain and accept keeps out_valid high.
      if (out_valid && out_ready) out_valid <= 1'b0;

      if (!legal) begin
        state        <= ST_IDLE;
        mode         <= MODE_OFF;
        count        <= '0;
        mode_changed <= (mode != MODE_OFF);
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              if (in_data == ESC_CODE) begin
                state <= ST_GOT_ESC;
                count <= '0;
              end else if (mode != MODE_OFF) begin
                out_data  <= xformed;
                out_valid <= 1'b1;
              end
            end
          end
          ST_GOT_ESC: begin
            if (accept) begin
              state <= ST_IDLE;
              count <= '0;
              case (in_data)
                CMD_OFF: begin
                  mode         <= MODE_OFF;
                  mode_changed <= (mode != MODE_OFF);
                end
                CMD_PASS: begin
                  mode         <= MODE_PASS;
                  mode_changed <= (mode != MODE_PASS);
                end
                CMD_UPPER: begin
                  mode         <= MODE_UPPER;
                  mode_changed <= (mode != MODE_UPPER);
                end
                CMD_LOWER: begin
                  mode         <= MODE_LOWER;
                  mode_changed <= (mode != MODE_LOWER);
                end
                ESC_CODE: begin
                  if (mode != MODE_OFF) begin
                    out_data  <= ESC_CODE;
                    out_valid <= 1'b1;
                  end
                end
                default: esc_error <= 1'b1;
              endcase
            end else if (TIMEOUT_CYC != 0) begin
              if (32'(count) == TIMEOUT_CYC - 1) begin
                state     <= ST_IDLE;
                count     <= '0;
                esc_error <= 1'b1;
              end else begin
                count <= count + 1'b1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_esc_mode_sequencer.sv
// Directed self-checking bench for esc_mode_sequencer.
module tb_esc_mode_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       off, pass, upper, lower;
  logic       mode_changed;
  logic       esc_error;

  int vectors;
  int miscompares;

  esc_mode_sequencer #(
    .DATA_W      (8),
    .ESC_CODE    (8'h1B),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .off          (off),
    .pass         (pass),
    .upper        (upper),
    .lower        (lower),
    .mode_changed (mode_changed),
    .esc_error    (esc_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs, clock once, settle past the edge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic rdy);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_mode(input string tag, input logic [3:0] exp_lupo);
    chk(tag, {4'b0, lower, upper, pass, off}, {4'b0, exp_lupo});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    out_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk_mode("rst_mode", 4'b0001);
    chk("rst_out_valid", {7'b0, out_valid}, 8'h00);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_mode_changed", {7'b0, mode_changed}, 8'h00);
    chk("rst_esc_error", {7'b0, esc_error}, 8'h00);
    chk("rst_in_ready", {7'b0, in_ready}, 8'h01);
    rst_n = 1'b1;

    // OFF drops data
    cyc(1, 8'h41, 1); chk("off_drop0", {7'b0, out_valid}, 8'h00);
    cyc(1, 8'h62, 1); chk("off_drop1", {7'b0, out_valid}, 8'h00);
    chk_mode("off_still", 4'b0001);

    // ESC 'U' then "aZ1" plus boundary bytes
    cyc(1, 8'h1B, 1); chk("esc_u_esc_nofwd", {7'b0, out_valid}, 8'h00);
    cyc(1, 8'h55, 1); chk_mode("upper_mode", 4'b0100);
    chk("upper_mc", {7'b0, mode_changed}, 8'h01);
    chk("upper_cmd_nofwd", {7'b0, out_valid}, 8'h00);
    cyc(1, 8'h61, 1); chk("up_a", out_data, 8'h41); chk("up_a_v", {7'b0, out_valid}, 8'h01);
    chk("up_mc_gone", {7'b0, mode_changed}, 8'h00);
    cyc(1, 8'h5A, 1); chk("up_Z", out_data, 8'h5A); chk("up_Z_v", {7'b0, out_valid}, 8'h01);
    cyc(1, 8'h31, 1); chk("up_1", out_data, 8'h31);
    cyc(1, 8'h60, 1); chk("up_60", out_data, 8'h60);
    cyc(1, 8'h7B, 1); chk("up_7b", out_data, 8'h7B);
    cyc(1, 8'h7A, 1); chk("up_z", out_data, 8'h5A);
    cyc(0, 8'h00, 1); chk("up_drain", {7'b0, out_valid}, 8'h00);

    // ESC 'L' from UPPER, then repeat command
    cyc(1, 8'h1B, 1);
    cyc(1, 8'h4C, 1); chk_mode("lower_mode", 4'b1000);
    chk("lower_mc", {7'b0, mode_changed}, 8'h01);
    cyc(1, 8'h4D, 1); chk("lo_M", out_data, 8'h6D);
    cyc(1, 8'h6E, 1); chk("lo_n", out_data, 8'h6E);
    cyc(1, 8'h40, 1); chk("lo_40", out_data, 8'h40);
    cyc(1, 8'h5B, 1); chk("lo_5b", out_data, 8'h5B);
    cyc(1, 8'h41, 1); chk("lo_A", out_data, 8'h61);
    cyc(1, 8'h1B, 1); chk("lo_esc_nofwd", {7'b0, out_valid}, 8'h00);
    cyc(1, 8'h4C, 1); chk("lower_again_mc", {7'b0, mode_changed}, 8'h00);
    chk_mode("lower_again", 4'b1000);
    chk("lower_again_nofwd", {7'b0, out_valid}, 8'h00);

    // PASS, literal ESC, unknown command
    cyc(1, 8'h1B, 1);
    cyc(1, 8'h50, 1); chk_mode("pass_mode", 4'b0010);
    chk("pass_mc", {7'b0, mode_changed}, 8'h01);
    cyc(1, 8'h1B, 1);
    cyc(1, 8'h1B, 1); chk("lit_esc", out_data, 8'h1B); chk("lit_esc_v", {7'b0, out_valid}, 8'h01);
    cyc(1, 8'h7A, 1); chk("pass_z", out_data, 8'h7A);
    cyc(1, 8'h1B, 1);
    cyc(1, 8'h51, 1); chk("bad_cmd_err", {7'b0, esc_error}, 8'h01);
    chk("bad_cmd_nofwd", {7'b0, out_valid}, 8'h00);
    chk_mode("bad_cmd_mode", 4'b0010);
    chk("bad_cmd_mc", {7'b0, mode_changed}, 8'h00);
    cyc(0, 8'h00, 1); chk("err_pulse_end", {7'b0, esc_error}, 8'h00);

    // Timeout after 16 idle cycles in GOT_ESC
    cyc(1, 8'h1B, 1);
    for (int i = 0; i < 15; i++) cyc(0, 8'h00, 1);
    chk("tmo_not_yet", {7'b0, esc_error}, 8'h00);
    cyc(0, 8'h00, 1); chk("tmo_err", {7'b0, esc_error}, 8'h01);
    chk_mode("tmo_mode", 4'b0010);
    cyc(1, 8'h55, 1); chk("tmo_data", out_data, 8'h55);
    chk("tmo_data_v", {7'b0, out_valid}, 8'h01);
    chk_mode("tmo_no_cmd", 4'b0010);
    chk("tmo_err_end", {7'b0, esc_error}, 8'h00);
    cyc(0, 8'h00, 1);

    // Backpressure
    cyc(1, 8'hA0, 0); chk("bp_load", out_data, 8'hA0);
    in_valid = 1'b1; in_data = 8'hA1; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", {7'b0, in_ready}, 8'h00);
      @(posedge clk); #1;
      chk("bp_hold", out_data, 8'hA0);
      chk("bp_hold_v", {7'b0, out_valid}, 8'h01);
    end
    cyc(1, 8'hA1, 1); chk("bp_rel_a1", out_data, 8'hA1); chk("bp_rel_v", {7'b0, out_valid}, 8'h01);
    cyc(1, 8'hA2, 1); chk("bp_rel_a2", out_data, 8'hA2);
    in_valid = 1'b1; in_data = 8'hA3;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {7'b0, out_valid}, 8'h00);
    chk_mode("midrst_mode", 4'b0001);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(1, 8'h41, 1); chk("post_rst_off", {7'b0, out_valid}, 8'h00);
    cyc(0, 8'h00, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/esc_mode_sequencer.md
Name: esc_mode_sequencer

Overview:
- Byte-stream controller that decodes in-band escape commands and sequences the character case-conversion datapath: OFF (drop), PASS (forward unchanged), UPPER (a-z -> A-Z), LOWER (A-Z -> a-z).
- Sits between the character source and the downstream sink.
- Exports one-hot mode flags and change/error pulses for status logic.

Parameters:
- DATA_W, 8, byte width; only 8 supported.
- ESC_CODE, 8'h1B, escape introducer byte.
- TIMEOUT_CYC, 16, maximum number of cycles allowed in GOT_ESC without an accepted byte; 0 disables the timeout.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_data  input  DATA_W  incoming byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  byte accepted when in_valid && in_ready.
- out_data  output  DATA_W  registered output byte.
- out_valid  output  1  out_data valid.
- out_ready  input  1  sink accepts when out_valid && out_ready.
- off, pass, upper, lower  output  1 each  one-hot current mode, registered.
- mode_changed  output  1  one-cycle pulse when the mode register changes value.
- esc_error  output  1  one-cycle pulse on an unknown command or a timeout.

Behaviour:
- Reset (reset=0, asynchronous):
  - mode=OFF, so off=1 and pass/upper/lower=0.
  - out_valid=0, out_data=0, mode_changed=0, esc_error=0.
  - FSM=IDLE, timeout counter=0.
- in_ready = !out_valid || out_ready in all states. in_ready is combinational and must not depend on in_valid.
- FSM states are IDLE and GOT_ESC. Mode register (OFF/PASS/UPPER/LOWER) is held separately.
- IDLE, byte accepted:
  - byte==ESC_CODE -> GOT_ESC; the byte is not forwarded.
  - any other byte, mode OFF -> byte dropped.
  - any other byte, mode PASS -> forwarded unchanged.
  - mode UPPER -> 0x61..0x7A have 0x20 subtracted; all other bytes unchanged.
  - mode LOWER -> 0x41..0x5A have 0x20 added; all other bytes unchanged.
- GOT_ESC, byte accepted (always returns to IDLE):
  - 'O' 0x4F -> mode OFF.
  - 'P' 0x50 -> mode PASS.
  - 'U' 0x55 -> mode UPPER.
  - 'L' 0x4C -> mode LOWER.
  - ESC_CODE -> literal ESC_CODE is forwarded untransformed if mode != OFF; dropped in OFF.
  - any other byte -> both bytes dropped, esc_error pulses, mode unchanged.
  - Command bytes are never forwarded.
- Timing:
  - A mode change is visible on the flags the cycle after the command byte is accepted and applies to the next accepted byte.
  - mode_changed pulses in that same cycle, and only if the new mode differs from the old one.
  - Forwarded data has latency 1: out_data/out_valid update on the clock edge that accepts the byte.
  - out_valid drops when out_ready=1 and no new forwardable byte is accepted that cycle.
  - Simultaneous drain and accept loads the new byte, so out_valid stays 1.
  - out_data is held stable while out_valid && !out_ready.
- Timeout:
  - The counter clears on entry to GOT_ESC and increments every cycle in GOT_ESC with no accepted byte.
  - When the count reaches TIMEOUT_CYC: return to IDLE, pulse esc_error, keep mode; the pending ESC is discarded.
  - An accept on the expiry cycle takes priority: the byte is decoded as a command and no error is raised.
- Illegal FSM or non-one-hot mode encoding -> FSM=IDLE, mode=OFF on the next edge.
- Reset mid-stream discards any pending out_data and any pending ESC.

Test Plan:
- Reset release, then bytes 0x41,0x62 with out_ready=1 -> no out_valid (mode OFF); off=1.
- ESC,'U', then "aZ1" -> mode_changed pulse once; upper=1; out_data sequence 0x41,0x5A,0x31 at one byte per cycle.
- In UPPER, ESC,'L' then 0x4D,0x6E; then ESC,'L' again -> outputs 0x6D,0x6E; the second command gives no mode_changed pulse.
- In PASS, ESC,ESC,0x7A -> outputs 0x1B,0x7A. ESC,0x51 -> esc_error pulse, nothing forwarded, pass stays 1.
- In PASS, ESC then idle for 16 cycles -> esc_error pulses at cycle 16 and FSM returns to IDLE; next 0x55 is output as 0x55 (data, not a command).
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_data stable; on release, bytes emerge in order with no loss or duplication. Assert reset mid-burst -> out_valid=0 immediately and off=1.
